rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the width of the write data.
REQ-002 SHALL have parameter CNT_W, default 8, the width of the conflict counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 a_valid  input  1  ALU writeback request.
REQ-007 a_reg  input  4  ALU destination register id.
REQ-008 a_data  input  DATA_W  ALU writeback data.
REQ-009 a_ready  output  1  ALU request accepted this cycle.
REQ-010 b_valid  input  1  memory-load writeback request.
REQ-011 b_reg  input  4  memory destination register id.
REQ-012 b_data  input  DATA_W  memory writeback data.
REQ-013 b_ready  output  1  memory request accepted this cycle.
REQ-014 rf_hold  input  1  register file cannot take a write this cycle.
REQ-015 wr_en  output  1  register file write strobe (registered).
REQ-016 wr_line  output  16  one-hot register write-enable line (registered).
REQ-017 wr_data  output  DATA_W  register file write data (registered).
REQ-018 last_grant  output  1  requester granted most recently: 0 = A, 1 = B.
REQ-019 conflict_cnt  output  CNT_W  saturating count of arbitration conflicts.

Function
REQ-020 A transfer SHALL occur on a requester when its valid and ready are both high at a rising clk edge.
REQ-021 a_ready and b_ready SHALL be combinational, mutually exclusive, and both low while rf_hold=1.
REQ-022 Exactly one valid requester with rf_hold=0 SHALL be granted (its ready high) in the same cycle.
REQ-023 When both requesters are valid, the grant SHALL follow a round-robin priority FSM:
  - PRI_A: grant A.
  - PRI_B: grant B.
REQ-024 After any grant, the FSM SHALL move to the priority state of the other requester; with no grant, the state SHALL hold.
REQ-025 last_grant SHALL update on every grant and hold otherwise.
REQ-026 Latency: a transfer at edge N SHALL drive wr_en, wr_line and wr_data at edge N (visible in cycle N+1), for exactly one cycle.
REQ-027 wr_line SHALL be the one-hot 4-to-16 decode of the granted register id; wr_data SHALL be the granted data.
REQ-028 A transfer with register id 0 SHALL be accepted (ready high) but dropped: wr_en=0 and wr_line=0 the next cycle, since R0 is read-only.
REQ-029 A cycle with no transfer SHALL drive wr_en=0 and wr_line=0 the next cycle; wr_data SHALL hold its last value.
REQ-030 Two requesters valid to the same register SHALL be serialized in round-robin order; the later write SHALL win in the register file.
REQ-031 conflict_cnt SHALL increment by 1 on each cycle where both valid=1, rf_hold=0 and one requester is denied.
REQ-032 conflict_cnt SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-033 Cycles with rf_hold=1 SHALL NOT count as conflicts.
REQ-034 A requester SHALL hold valid, reg and data stable until accepted; the arbiter SHALL NOT depend on this for correctness of outputs.

Reset
REQ-035 On rst assertion, independent of clk, the block SHALL clear wr_en=0, wr_line=0, wr_data=0, last_grant=1 and conflict_cnt=0, and set the FSM to PRI_A.
REQ-036 While rst=1, a_ready and b_ready SHALL be 0.
REQ-037 A write pending in the output register when rst asserts SHALL be discarded and never strobed.

Verification
REQ-038 A only, a_reg=5, a_data=0x1234 -> a_ready=1 same cycle; next cycle wr_en=1, wr_line=0x0020, wr_data=0x1234.
REQ-039 A and B both valid for 4 cycles from reset (a_reg=3, b_reg=7) -> grants A,B,A,B; wr_line 0x0008,0x0080,0x0008,0x0080; conflict_cnt=4.
REQ-040 b_reg=0 with b_valid=1 -> b_ready=1; next cycle wr_en=0, wr_line=0x0000.
REQ-041 Both valid with rf_hold=1 for 3 cycles -> readies 0, wr_en=0, conflict_cnt and FSM unchanged; on release, the pending-priority requester is granted first.
REQ-042 Both valid for 300 cycles with CNT_W=8 -> conflict_cnt stops at 255.
REQ-043 rst asserted mid-cycle after a grant to reg 9 -> wr_en and wr_line drop to 0 immediately; no strobe of 0x0200 follows.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: round-robin grant between ALU (A)
// and memory-load (B) writebacks, registered one-hot write port, conflict counter.
module rf_write_arbiter #(
   parameter int DATA_W = 16,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_valid,
   input  logic [3:0]        a_reg,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [3:0]        b_reg,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   input  logic              rf_hold,
   output logic              wr_en,
   output logic [15:0]       wr_line,
   output logic [DATA_W-1:0] wr_data,
   output logic              last_grant,
   output logic [CNT_W-1:0]  conflict_cnt
);

   typedef enum logic {
      PRI_A = 1'b0,
      PRI_B = 1'b1
   } pri_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   pri_e              state;
   pri_e              state_next;
   logic              grant_a;
   logic              grant_b;
   logic              grant;
   logic              conflict;
   logic [3:0]        sel_reg;
   logic [DATA_W-1:0] sel_data;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      state_next = state;
      if (!rst && !rf_hold) begin
         if (a_valid && b_valid) begin
            grant_a = (state == PRI_A);
            grant_b = (state == PRI_B);
         end else begin
            grant_a = a_valid;
            grant_b = b_valid;
         end
      end
      if (grant_a) begin
         state_next = PRI_B;
      end else if (grant_b) begin
         state_next = PRI_A;
      end
   end

   assign a_ready  = grant_a;
   assign b_ready  = grant_b;
   assign grant    = grant_a | grant_b;
   assign conflict = a_valid & b_valid & ~rf_hold & ~rst;
   assign sel_reg  = grant_b ? b_reg : a_reg;
   assign sel_data = grant_b ? b_data : a_data;

   // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= PRI_A;
      end else begin
         state <= state_next;
      end
   end

   // Writes to R0 are accepted but never strobed; the register is read-only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en      <= 1'b0;
         wr_line    <= '0;
         wr_data    <= '0;
         last_grant <= 1'b1;
      end else begin
         wr_en   <= grant && (sel_reg != 4'd0);
         wr_line <= (grant && (sel_reg != 4'd0)) ? (16'd1 << sel_reg) : 16'd0;
         if (grant) begin
            wr_data    <= sel_data;
            last_grant <= grant_b;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt <= '0;
      end else if (conflict && (conflict_cnt != CNT_MAX)) begin
         conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized self-checking bench for rf_write_arbiter against a behavioural
// model of the arbitration rules and a shadow register file.
module tb_rf_write_arbiter;

   localparam int DATA_W = 16;
   localparam int CNT_W  = 8;
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              a_valid = 1'b0;
   logic [3:0]        a_reg = '0;
   logic [DATA_W-1:0] a_data = '0;
   logic              a_ready;
   logic              b_valid = 1'b0;
   logic [3:0]        b_reg = '0;
   logic [DATA_W-1:0] b_data = '0;
   logic              b_ready;
   logic              rf_hold = 1'b0;
   logic              wr_en;
   logic [15:0]       wr_line;
   logic [DATA_W-1:0] wr_data;
   logic              last_grant;
   logic [CNT_W-1:0]  conflict_cnt;

   rf_write_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .a_valid      (a_valid),
      .a_reg        (a_reg),
      .a_data       (a_data),
      .a_ready      (a_ready),
      .b_valid      (b_valid),
      .b_reg        (b_reg),
      .b_data       (b_data),
      .b_ready      (b_ready),
      .rf_hold      (rf_hold),
      .wr_en        (wr_en),
      .wr_line      (wr_line),
      .wr_data      (wr_data),
      .last_grant   (last_grant),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: whose turn it is on a tie, plus the expected outputs.
   bit                b_turn;
   bit                m_last;
   int                m_cnt;
   bit                m_wr_en;
   logic [15:0]       m_line;
   logic [DATA_W-1:0] m_data;
   logic [DATA_W-1:0] rf_model [16];
   logic [DATA_W-1:0] rf_dut   [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      b_turn  = 1'b0;
      m_last  = 1'b1;
      m_cnt   = 0;
      m_wr_en = 1'b0;
      m_line  = '0;
      m_data  = '0;
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".wr_en"},   32'(wr_en),        32'(m_wr_en));
      check({tag, ".wr_line"}, 32'(wr_line),      32'(m_line));
      check({tag, ".wr_data"}, 32'(wr_data),      32'(m_data));
      check({tag, ".last"},    32'(last_grant),   32'(m_last));
      check({tag, ".cnt"},     32'(conflict_cnt), 32'(m_cnt));
   endtask

   // Called at posedge+1; drives inputs, checks readies, crosses one edge, checks outputs.
   task automatic drive_cycle(input string tag,
                              input bit av, input logic [3:0] ar, input logic [DATA_W-1:0] ad,
                              input bit bv, input logic [3:0] br, input logic [DATA_W-1:0] bd,
                              input bit hold);
      bit ga, gb;
      int dest;
      logic [DATA_W-1:0] val;
      a_valid = av; a_reg = ar; a_data = ad;
      b_valid = bv; b_reg = br; b_data = bd;
      rf_hold = hold;
      ga = 1'b0;
      gb = 1'b0;
      if (!hold) begin
         if (av && bv) begin
            if (b_turn) gb = 1'b1; else ga = 1'b1;
         end else begin
            ga = av;
            gb = bv;
         end
      end
      #1;
      check({tag, ".a_ready"}, 32'(a_ready), 32'(ga));
      check({tag, ".b_ready"}, 32'(b_ready), 32'(gb));
      @(posedge clk);
      #1;
      if (av && bv && !hold && m_cnt < CNT_SAT) m_cnt++;
      if (ga || gb) begin
         dest    = ga ? int'(ar) : int'(br);
         val     = ga ? ad : bd;
         b_turn  = ga;
         m_last  = gb;
         m_data  = val;
         m_wr_en = (dest != 0);
         m_line  = (dest != 0) ? 16'(2 ** dest) : 16'd0;
         if (dest != 0) rf_model[dest] = val;
      end else begin
         m_wr_en = 1'b0;
         m_line  = '0;
      end
      if (wr_en) begin
         for (int i = 0; i < 16; i++) if (wr_line[i]) rf_dut[i] = wr_data;
      end
      check_outputs(tag);
   endtask

   task automatic idle(input string tag);
      drive_cycle(tag, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0);
   endtask

   // Called at posedge+1; holds reset across one edge with both requesters pushing.
   task automatic apply_reset();
      rst = 1'b1;
      a_valid = 1'b1; a_reg = 4'd2;
      b_valid = 1'b1; b_reg = 4'd4;
      rf_hold = 1'b0;
      #1;
      check("rst.a_ready", 32'(a_ready), 32'd0);
      check("rst.b_ready", 32'(b_ready), 32'd0);
      @(posedge clk);
      #1;
      model_reset();
      check_outputs("rst");
      rst = 1'b0;
   endtask

   initial begin
      int saved_cnt;
      for (int i = 0; i < 16; i++) begin
         rf_model[i] = '0;
         rf_dut[i]   = '0;
      end
      model_reset();
      @(posedge clk);
      #1;
      apply_reset();

      // Single ALU write.
      drive_cycle("a_only", 1'b1, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0, 1'b0);
      check("a_only.line_const", 32'(wr_line), 32'h0020);
      idle("a_only.after");

      // Four-cycle tie from reset alternates A,B,A,B.
      apply_reset();
      for (int i = 0; i < 4; i++)
         drive_cycle("rr", 1'b1, 4'd3, 16'(16'h0A00 + i), 1'b1, 4'd7, 16'(16'h0B00 + i), 1'b0);
      check("rr.cnt_const", 32'(conflict_cnt), 32'd4);

      // Write to R0 is accepted and dropped.
      drive_cycle("r0", 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 16'hDEAD, 1'b0);
      check("r0.line_const", 32'(wr_line), 32'h0000);

      // Hold freezes arbitration; pending priority (B after an A grant) wins on release.
      apply_reset();
      drive_cycle("hold.pre", 1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0);
      saved_cnt = m_cnt;
      for (int i = 0; i < 3; i++)
         drive_cycle("hold", 1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b1);
      check("hold.cnt_frozen", 32'(conflict_cnt), 32'(saved_cnt));
      a_valid = 1'b1; b_valid = 1'b1; rf_hold = 1'b0;
      #1;
      check("hold.release_b", 32'(b_ready), 32'd1);
      @(negedge clk);
      drive_cycle("hold.release", 1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222, 1'b0);

      // Long tie saturates the counter.
      apply_reset();
      for (int i = 0; i < 300; i++)
         drive_cycle("sat", 1'b1, 4'(1 + (i % 15)), 16'(i), 1'b1, 4'(15 - (i % 15)), 16'(~i), 1'b0);
      check("sat.cnt_const", 32'(conflict_cnt), 32'd255);

      // Reset arriving mid-cycle discards the pending write to R9.
      apply_reset();
      drive_cycle("mid_rst.grant", 1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 16'h0, 1'b0);
      a_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst.wr_en_now",   32'(wr_en),   32'd0);
      check("mid_rst.wr_line_now", 32'(wr_line), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      idle("mid_rst.after");
      check("mid_rst.no_strobe", 32'(wr_line), 32'h0000);

      // Randomized traffic.
      apply_reset();
      for (int i = 0; i < 600; i++)
         drive_cycle("rand",
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                     ($urandom_range(0, 4) == 0));
      idle("rand.drain");

      for (int r = 1; r < 16; r++)
         check($sformatf("rf[%0d]", r), 32'(rf_dut[r]), 32'(rf_model[r]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
